// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle controller and the TSC datapath.
// The controller side is the master: it observes IR/bcond/mem_ready and
// drives every datapath enable plus the status outputs.
interface multicycle_control_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
);
  logic [WORD_SIZE-1:0] instr;
  logic                 bcond;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_wr_cond;
  logic [1:0]           pc_source;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           reg_dst;
  logic                 mem_to_reg;
  logic                 pc_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 out_en;
  logic                 is_halted;
  logic                 mem_err;
  logic [CNT_W-1:0]     num_inst;

  modport master (
    input  instr, bcond, mem_ready,
    output pc_write, pc_wr_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, pc_to_reg, alu_src_a,
           alu_src_b, out_en, is_halted, mem_err, num_inst
  );

  modport slave (
    output instr, bcond, mem_ready,
    input  pc_write, pc_wr_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, pc_to_reg, alu_src_a,
           alu_src_b, out_en, is_halted, mem_err, num_inst
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM controller for the 16-bit TSC datapath.
// Walks each instruction through IF/ID/EX/MEM/WB, stalls on mem_ready,
// counts retired instructions and stops in HALT on HLT or a memory timeout.
// bcond is consumed by the datapath together with pc_wr_cond, so the
// controller itself never needs its value.
module multicycle_control_unit #(
  parameter int WORD_SIZE   = 16,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RTY = 4'd15;

  localparam logic [5:0] FN_ALU_MAX = 6'd7;
  localparam logic [5:0] FN_JPR     = 6'd25;
  localparam logic [5:0] FN_JRL     = 6'd26;
  localparam logic [5:0] FN_WWD     = 6'd28;
  localparam logic [5:0] FN_HLT     = 6'd29;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   num_inst_q;
  logic               mem_err_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               retire;
  logic               waiting;
  logic               timeout;

  logic [3:0] opcode;
  logic [5:0] funct;
  logic       is_branch, is_alu_r, is_adi, is_zimm, is_lwd, is_swd;
  logic       is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt, goes_ex;
  logic       unused_inputs;

  assign opcode = bus.instr[WORD_SIZE-1 -: 4];
  assign funct  = bus.instr[5:0];

  assign is_branch = (opcode >= OP_BNE) && (opcode <= OP_BLZ);
  assign is_adi    = (opcode == OP_ADI);
  assign is_zimm   = (opcode == OP_ORI) || (opcode == OP_LHI);
  assign is_lwd    = (opcode == OP_LWD);
  assign is_swd    = (opcode == OP_SWD);
  assign is_jmp    = (opcode == OP_JMP);
  assign is_jal    = (opcode == OP_JAL);
  assign is_alu_r  = (opcode == OP_RTY) && (funct <= FN_ALU_MAX);
  assign is_jpr    = (opcode == OP_RTY) && (funct == FN_JPR);
  assign is_jrl    = (opcode == OP_RTY) && (funct == FN_JRL);
  assign is_wwd    = (opcode == OP_RTY) && (funct == FN_WWD);
  assign is_hlt    = (opcode == OP_RTY) && (funct == FN_HLT);
  assign goes_ex   = is_branch | is_alu_r | is_adi | is_zimm | is_lwd | is_swd;

  assign unused_inputs = &{1'b0, bus.bcond, bus.instr[WORD_SIZE-5:6]};

  // A memory access is stalling whenever IF or MEM sees no mem_ready.
  assign waiting = ((state == S_IF) || (state == S_MEM)) && !bus.mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting &&
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // State, retire counter, sticky error flag and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IF;
      num_inst_q <= '0;
      mem_err_q  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state <= state_next;
      if (retire)  num_inst_q <= num_inst_q + CNT_W'(1);
      if (timeout) mem_err_q  <= 1'b1;
      wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  // Next state and the retire strobe for the last state of each instruction.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IF: begin
        if (bus.mem_ready) state_next = S_ID;
        else if (timeout)  state_next = S_HALT;
      end
      S_ID: begin
        if (is_hlt) begin
          state_next = S_HALT;
          retire     = 1'b1;
        end else if (goes_ex) begin
          state_next = S_EX;
        end else begin
          state_next = S_IF;
          retire     = 1'b1;
        end
      end
      S_EX: begin
        if (is_branch) begin
          state_next = S_IF;
          retire     = 1'b1;
        end else if (is_lwd || is_swd) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (is_lwd) begin
            state_next = S_WB;
          end else begin
            state_next = S_IF;
            retire     = 1'b1;
          end
        end else if (timeout) begin
          state_next = S_HALT;
        end
      end
      S_WB: begin
        state_next = S_IF;
        retire     = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  // Per-state datapath enables; everything reads zero while reset is held.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_wr_cond = 1'b0;
    bus.pc_source  = 2'd0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 1'b0;
    bus.pc_to_reg  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.out_en     = 1'b0;
    bus.is_halted  = 1'b0;
    bus.mem_err    = 1'b0;
    bus.num_inst   = '0;
    if (!reset) begin
      bus.num_inst  = num_inst_q;
      bus.mem_err   = mem_err_q;
      bus.is_halted = (state == S_HALT);
      case (state)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_ID: begin
          bus.alu_src_b = 2'd2;
          bus.pc_write  = is_jmp | is_jal | is_jpr | is_jrl;
          if (is_jpr || is_jrl)      bus.pc_source = 2'd3;
          else if (is_jmp || is_jal) bus.pc_source = 2'd2;
          if (is_jal || is_jrl) begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 2'd2;
            bus.pc_to_reg = 1'b1;
          end
          bus.out_en = is_wwd;
        end
        S_EX: begin
          bus.alu_src_a = 1'b1;
          if (is_adi || is_lwd || is_swd) bus.alu_src_b = 2'd2;
          else if (is_zimm)               bus.alu_src_b = 2'd3;
          if (is_branch) begin
            bus.pc_wr_cond = 1'b1;
            bus.pc_source  = 2'd1;
          end
        end
        S_MEM: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = is_lwd;
          bus.mem_write = is_swd;
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = is_alu_r ? 2'd0 : 2'd1;
          bus.mem_to_reg = is_lwd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for the multi-cycle controller. A driver plays the role of
// memory and datapath, and for every cycle pushes the control word the
// instruction-level model expects; a monitor pops and compares each cycle.
module tb_multicycle_control_unit;

  localparam int WORD_SIZE   = 16;
  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic        pc_write;
    logic        pc_wr_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        mem_to_reg;
    logic        pc_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        out_en;
    logic        is_halted;
    logic        mem_err;
    logic [15:0] num_inst;
  } ctrl_t;

  typedef enum {K_RALU, K_ADI, K_ZIMM, K_LWD, K_SWD, K_BR, K_JMP, K_JAL,
                K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_t;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_unit_if #(.WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ctrl_t exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    model_count  = 0;
  logic  model_err    = 1'b0;

  // Instruction class straight from the TSC opcode/funct table.
  function automatic kind_t classify(input logic [15:0] ins);
    logic [5:0] fn;
    fn = ins[5:0];
    case (ins[15:12])
      4'd0, 4'd1, 4'd2, 4'd3: return K_BR;
      4'd4:                   return K_ADI;
      4'd5, 4'd6:             return K_ZIMM;
      4'd7:                   return K_LWD;
      4'd8:                   return K_SWD;
      4'd9:                   return K_JMP;
      4'd10:                  return K_JAL;
      4'd15: begin
        if (fn < 6'd8)   return K_RALU;
        if (fn == 6'd25) return K_JPR;
        if (fn == 6'd26) return K_JRL;
        if (fn == 6'd28) return K_WWD;
        if (fn == 6'd29) return K_HLT;
        return K_NOP;
      end
      default:                return K_NOP;
    endcase
  endfunction

  function automatic ctrl_t idle();
    ctrl_t c;
    c          = '0;
    c.num_inst = model_count[15:0];
    c.mem_err  = model_err;
    return c;
  endfunction

  // Drive one cycle of inputs and record what the outputs must be in it.
  task automatic applyStimulus(input logic rst, input logic rdy,
                               input logic [15:0] ins, input ctrl_t exp,
                               input string nm);
    reset         = rst;
    bus.mem_ready = rdy;
    bus.instr     = ins;
    bus.bcond     = 1'($urandom_range(0, 1));
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input ctrl_t act, input ctrl_t exp, input string nm);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), ctrl_t'(0), "reset");
    model_count = 0;
    model_err   = 1'b0;
  endtask

  task automatic fetch(input int waits);
    ctrl_t c;
    c           = idle();
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    for (int i = 0; i < waits; i++) applyStimulus(1'b0, 1'b0, 16'($urandom), c, "if_wait");
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'($urandom), c, "if_done");
  endtask

  task automatic fetchTimeout();
    ctrl_t c;
    c           = idle();
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(1'b0, 1'b0, 16'($urandom), c, "if_timeout_wait");
    model_err = 1'b1;
  endtask

  task automatic haltCycles(input int n);
    ctrl_t c;
    for (int i = 0; i < n; i++) begin
      c           = idle();
      c.is_halted = 1'b1;
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), c, "halted");
    end
  endtask

  // One instruction from fetch to retirement. mem_wait >= MEM_TIMEOUT means the
  // data access never completes; abort_mem >= 0 asserts reset in that MEM wait.
  task automatic runInstr(input logic [15:0] ins, input int if_wait,
                          input int mem_wait, input int abort_mem);
    kind_t k;
    ctrl_t c;
    k = classify(ins);
    fetch(if_wait);

    c           = idle();
    c.alu_src_b = 2'd2;
    case (k)
      K_JMP: begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
      K_JPR: begin c.pc_write = 1'b1; c.pc_source = 2'd3; end
      K_JAL, K_JRL: begin
        c.pc_write  = 1'b1;
        c.pc_source = (k == K_JAL) ? 2'd2 : 2'd3;
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd2;
        c.pc_to_reg = 1'b1;
      end
      K_WWD:   c.out_en = 1'b1;
      default: ;
    endcase
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), ins, c, "decode");
    if (k inside {K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_NOP, K_HLT}) begin
      model_count++;
      return;
    end

    c           = idle();
    c.alu_src_a = 1'b1;
    if (k inside {K_ADI, K_LWD, K_SWD}) c.alu_src_b = 2'd2;
    else if (k == K_ZIMM)               c.alu_src_b = 2'd3;
    if (k == K_BR) begin
      c.pc_wr_cond = 1'b1;
      c.pc_source  = 2'd1;
    end
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), ins, c, "execute");
    if (k == K_BR) begin
      model_count++;
      return;
    end

    if (k == K_LWD || k == K_SWD) begin
      c           = idle();
      c.i_or_d    = 1'b1;
      c.mem_read  = (k == K_LWD);
      c.mem_write = (k == K_SWD);
      for (int i = 0; i < mem_wait && i < MEM_TIMEOUT; i++) begin
        if (i == abort_mem) begin
          doReset();
          return;
        end
        applyStimulus(1'b0, 1'b0, ins, c, "mem_wait");
      end
      if (mem_wait >= MEM_TIMEOUT) begin
        model_err = 1'b1;
        return;
      end
      applyStimulus(1'b0, 1'b1, ins, c, "mem_done");
      if (k == K_SWD) begin
        model_count++;
        return;
      end
    end

    c            = idle();
    c.reg_write  = 1'b1;
    c.reg_dst    = (k == K_RALU) ? 2'd0 : 2'd1;
    c.mem_to_reg = (k == K_LWD);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), ins, c, "writeback");
    model_count++;
  endtask

  function automatic logic [15:0] randomInstr();
    logic [15:0] ins;
    logic [5:0]  fn;
    ins = 16'($urandom);
    if (ins[15:12] == 4'd15) begin
      case ($urandom_range(0, 3))
        0:       fn = 6'($urandom_range(0, 7));
        1:       fn = 6'd25 + 6'($urandom_range(0, 1));
        2:       fn = 6'd28;
        default: begin
          fn = 6'($urandom_range(8, 63));
          if (fn == 6'd29) fn = 6'd30;
        end
      endcase
      ins[5:0] = fn;
    end
    return ins;
  endfunction

  // Monitor: compares the DUT control word against the scoreboard each cycle.
  initial begin
    ctrl_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        act.pc_write   = bus.pc_write;
        act.pc_wr_cond = bus.pc_wr_cond;
        act.pc_source  = bus.pc_source;
        act.i_or_d     = bus.i_or_d;
        act.mem_read   = bus.mem_read;
        act.mem_write  = bus.mem_write;
        act.ir_write   = bus.ir_write;
        act.reg_write  = bus.reg_write;
        act.reg_dst    = bus.reg_dst;
        act.mem_to_reg = bus.mem_to_reg;
        act.pc_to_reg  = bus.pc_to_reg;
        act.alu_src_a  = bus.alu_src_a;
        act.alu_src_b  = bus.alu_src_b;
        act.out_en     = bus.out_en;
        act.is_halted  = bus.is_halted;
        act.mem_err    = bus.mem_err;
        act.num_inst   = bus.num_inst;
        checkOutput(act, exp_q.pop_front(), name_q.pop_front());
      end
    end
  end

  // Directed scenarios followed by a randomized instruction stream.
  initial begin
    reset         = 1'b1;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.bcond     = 1'b0;
    @(posedge clk);
    #1;
    doReset();
    doReset();

    runInstr({4'd4, 12'h123}, 0, 0, -1);
    runInstr({4'd7, 12'h0a5}, 0, 3, -1);
    runInstr({4'd1, 12'h0ff}, 0, 0, -1);
    runInstr({4'd1, 12'h001}, 0, 0, -1);
    runInstr({4'd10, 12'h345}, 0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] ins;
      ins = randomInstr();
      while (classify(ins) == K_HLT) ins = randomInstr();
      runInstr(ins, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5),
               $urandom_range(0, 5), -1);
    end

    runInstr({4'd8, 12'h010}, 1, 5, 2);
    runInstr({4'd5, 12'h777}, 2, 0, -1);
    runInstr({4'd15, 6'd0, 6'd28}, 0, 0, -1);

    runInstr({4'd15, 6'd0, 6'd29}, 0, 0, -1);
    haltCycles(20);
    doReset();
    runInstr({4'd4, 12'h001}, 0, 0, -1);

    fetchTimeout();
    haltCycles(5);
    doReset();

    runInstr({4'd7, 12'h002}, 0, MEM_TIMEOUT, -1);
    haltCycles(5);
    doReset();
    runInstr({4'd15, 6'd0, 6'd2}, 0, 0, -1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d pending expectations, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
